// File: rtl/adder_pkg.sv
// Shared constants and helpers for the carry-chunked pipelined adder.
package adder_pkg;

  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_CHUNK = 8;

  // Two's-complement overflow: carry into the sign bit disagrees with carry out of it.
  function automatic logic signed_ovf(input logic c_into_msb, input logic c_out_msb);
    return c_into_msb ^ c_out_msb;
  endfunction

endpackage

// File: rtl/adder_chunk.sv
// Combinational W-bit adder slice with carry-in; also exposes the carry into its MSB
// so the top slice can derive signed overflow.
module adder_chunk #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         c_msb
);

  logic [W:0] full_s;

  // Whole-slice add; the carry into the MSB is recovered from the MSB sum bit.
  always_comb begin
    full_s = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    sum    = full_s[W-1:0];
    cout   = full_s[W];
    c_msb  = a[W-1] ^ b[W-1] ^ full_s[W-1];
  end

endmodule

// File: rtl/pipelined_adder_nbits.sv
// WIDTH-bit adder summing CHUNK bits per pipeline stage with a valid/ready handshake.
// Each intermediate stage carries the finished low sum bits, the not-yet-added upper
// operand bits and the 1-bit carry; the final stage produces sum, cout and ovf.
module pipelined_adder_nbits
  import adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CHUNK = DEFAULT_CHUNK
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] s0,
  input  logic [WIDTH-1:0] s1,
  input  logic             cin,
  input  logic             valid_in,
  output logic             ready_in,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             valid_out,
  input  logic             ready_out
);

  localparam int STAGES = WIDTH / CHUNK;

  if ((WIDTH % CHUNK) != 0) begin : g_param_check
    $error("pipelined_adder_nbits: WIDTH must be a multiple of CHUNK");
  end

  // Final stage record: this register drives the outputs directly.
  typedef struct packed {
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             valid;
  } out_rec_t;

  out_rec_t out_r;
  out_rec_t out_d;

  logic advance_s;
  logic accept_s;

  // Global stall: every stage moves only when the output slot is empty or being drained.
  always_comb begin
    advance_s = !out_r.valid || ready_out;
    accept_s  = valid_in && advance_s;
  end

  assign ready_in = advance_s;

  // Intermediate stages 1..STAGES-1; stage i+1 holds LO finished sum bits.
  for (genvar i = 0; i < STAGES - 1; i++) begin : g_mid
    localparam int LO = (i + 1) * CHUNK;
    localparam int UW = WIDTH - LO;

    typedef struct packed {
      logic [LO-1:0] sum;
      logic [UW-1:0] a;
      logic [UW-1:0] b;
      logic          carry;
      logic          valid;
    } stage_rec_t;

    stage_rec_t       rec_r;
    stage_rec_t       rec_d;
    logic [CHUNK-1:0] ca_s;
    logic [CHUNK-1:0] cb_s;
    logic [CHUNK-1:0] csum_s;
    logic             cc_s;
    logic             cv_s;
    logic             ccout_s;
    logic             unused_cmsb_s;
    logic [UW-1:0]    ua_s;
    logic [UW-1:0]    ub_s;
    logic [LO-1:0]    psum_s;

    if (i == 0) begin : g_src
      // First stage takes its chunk straight from the input ports.
      always_comb begin
        ca_s   = s0[CHUNK-1:0];
        cb_s   = s1[CHUNK-1:0];
        cc_s   = cin;
        cv_s   = accept_s;
        ua_s   = s0[WIDTH-1:CHUNK];
        ub_s   = s1[WIDTH-1:CHUNK];
        psum_s = csum_s;
      end
    end else begin : g_src
      // Later stages take the lowest pending chunk of the previous stage's operands.
      always_comb begin
        ca_s   = g_mid[i-1].rec_r.a[CHUNK-1:0];
        cb_s   = g_mid[i-1].rec_r.b[CHUNK-1:0];
        cc_s   = g_mid[i-1].rec_r.carry;
        cv_s   = g_mid[i-1].rec_r.valid;
        ua_s   = g_mid[i-1].rec_r.a[UW+CHUNK-1:CHUNK];
        ub_s   = g_mid[i-1].rec_r.b[UW+CHUNK-1:CHUNK];
        psum_s = {csum_s, g_mid[i-1].rec_r.sum};
      end
    end

    adder_chunk #(.W(CHUNK)) u_chunk (
      .a    (ca_s),
      .b    (cb_s),
      .cin  (cc_s),
      .sum  (csum_s),
      .cout (ccout_s),
      .c_msb(unused_cmsb_s)
    );

    // Assemble the next record for this stage.
    always_comb begin
      rec_d.sum   = psum_s;
      rec_d.a     = ua_s;
      rec_d.b     = ub_s;
      rec_d.carry = ccout_s;
      rec_d.valid = cv_s;
    end

    // Stage register: cleared by reset, frozen while the pipe is stalled.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        rec_r <= '0;
      end else if (advance_s) begin
        rec_r <= rec_d;
      end
    end
  end

  logic [CHUNK-1:0] fin_a_s;
  logic [CHUNK-1:0] fin_b_s;
  logic [CHUNK-1:0] fin_sum_s;
  logic             fin_cin_s;
  logic             fin_v_s;
  logic             fin_cout_s;
  logic             fin_cmsb_s;
  logic [WIDTH-1:0] fin_full_s;

  if (STAGES == 1) begin : g_fin_src
    // Single-stage build: the final slice is the whole adder, fed from the ports.
    always_comb begin
      fin_a_s    = s0[CHUNK-1:0];
      fin_b_s    = s1[CHUNK-1:0];
      fin_cin_s  = cin;
      fin_v_s    = accept_s;
      fin_full_s = fin_sum_s;
    end
  end else begin : g_fin_src
    // Final slice consumes the last pending chunk and completes the sum.
    always_comb begin
      fin_a_s    = g_mid[STAGES-2].rec_r.a;
      fin_b_s    = g_mid[STAGES-2].rec_r.b;
      fin_cin_s  = g_mid[STAGES-2].rec_r.carry;
      fin_v_s    = g_mid[STAGES-2].rec_r.valid;
      fin_full_s = {fin_sum_s, g_mid[STAGES-2].rec_r.sum};
    end
  end

  adder_chunk #(.W(CHUNK)) u_fin_chunk (
    .a    (fin_a_s),
    .b    (fin_b_s),
    .cin  (fin_cin_s),
    .sum  (fin_sum_s),
    .cout (fin_cout_s),
    .c_msb(fin_cmsb_s)
  );

  // Final record: carry out and signed overflow come from the top slice.
  always_comb begin
    out_d.sum   = fin_full_s;
    out_d.cout  = fin_cout_s;
    out_d.ovf   = signed_ovf(fin_cmsb_s, fin_cout_s);
    out_d.valid = fin_v_s;
  end

  // Output register: reset forces sum/cout/ovf/valid to zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_r <= '0;
    end else if (advance_s) begin
      out_r <= out_d;
    end
  end

  assign sum       = out_r.sum;
  assign cout      = out_r.cout;
  assign ovf       = out_r.ovf;
  assign valid_out = out_r.valid;

endmodule
